// File: rtl/pipo_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipo_load_arbiter
// Description : Round-robin arbiter that shares one WIDTH-bit PIPO holding
//               register between NREQ requesters. The winner's word is loaded
//               and a one-cycle grant is pulsed back to it. The held word is
//               offered downstream with a valid/ready handshake.
//               Optional macro PIPO_ARB_FIXED_PRIO_EN selects fixed priority
//               (lowest index wins) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module pipo_load_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int SRC_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    input  logic                  q_ready,
    output logic [SRC_W-1:0]      q_src
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   w_eff;
    logic              w_found;
    logic [SRC_W-1:0]  w_winner;
    logic              w_load;
    logic [WIDTH-1:0]  w_data;

    // Mask the requester granted last cycle so a still-high req is not granted twice
    always_comb begin
        w_eff = req & ~gnt;
    end

`ifdef PIPO_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-index effective request wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
                w_found  = 1'b1;
                w_winner = SRC_W'(i);
            end
        end
    end
`else
    logic [SRC_W-1:0] r_last;

    // Round-robin: first effective request searching from last+1 upward, wrapping
    always_comb begin
        logic [SRC_W-1:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = SRC_W'((int'(r_last) + k) % NREQ);
            if (!w_found && w_eff[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    // Pointer starts at NREQ-1 so requester 0 has first priority after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SRC_W'(NREQ - 1);
        end else if (w_load) begin
            r_last <= w_winner;
        end
    end
`endif

    // Load when the register is free or being drained this cycle
    always_comb begin
        w_load = ((r_state == IDLE) || q_ready) && w_found;
    end

    // Steer the winner's word onto the load bus
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == SRC_W'(i)) begin
                w_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a load always lands in HOLD; a drain without reload returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_load) begin
                    w_state_nxt = HOLD;
                end else if (q_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Holding register, source tag and grant pulse; q/q_src change only on a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            q_src <= '0;
            gnt   <= '0;
        end else begin
            gnt <= '0;
            if (w_load) begin
                q     <= w_data;
                q_src <= w_winner;
                gnt   <= NREQ'(1) << w_winner;
            end
        end
    end

    assign q_valid = (r_state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_pipo_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipo_load_arbiter
// Description : Directed self-checking bench for pipo_load_arbiter. Expected
//               loads are queued as stimulus is driven and compared whenever
//               the DUT pulses a grant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipo_load_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int SRC_W = 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SRC_W-1:0] s;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic                  q_ready = 1'b0;
    logic [SRC_W-1:0]      q_src;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    pipo_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SRC_W(SRC_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_src    (q_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [SRC_W-1:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        sb.push_back(e);
    endtask

    // One clock: sample 1 time unit after the edge, check grant/valid and any load
    task automatic step(input string tag, input logic [NREQ-1:0] exp_gnt, input logic exp_valid);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, " q_valid"}, 32'(q_valid), 32'(exp_valid));
        if (gnt !== '0) begin
            chk({tag, " sb_pending"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, " q"}, 32'(q), 32'(e.d));
                chk({tag, " q_src"}, 32'(q_src), 32'(e.s));
            end
        end
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] d);
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("por q", 32'(q), 32'd0);
        chk("por q_valid", 32'(q_valid), 32'd0);
        chk("por gnt", 32'(gnt), 32'd0);
        chk("por q_src", 32'(q_src), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: async reset mid-HOLD, pointer returns to NREQ-1
        set_data(1, 4'b1101);
        req = 4'b0010;
        push(4'b1101, 2'd1);
        step("t1 load", 4'b0010, 1'b1);
        req = 4'b0000;
        step("t1 hold", 4'b0000, 1'b1);
        chk("t1 pre q", 32'(q), 32'hD);
        #3 rst_n = 1'b0;
        #1;
        chk("t1 rst q", 32'(q), 32'd0);
        chk("t1 rst q_valid", 32'(q_valid), 32'd0);
        chk("t1 rst gnt", 32'(gnt), 32'd0);
        chk("t1 rst q_src", 32'(q_src), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_data(0, 4'b1100);
        set_data(3, 4'b0110);
        req = 4'b1001;
        push(4'b1100, 2'd0);
        step("t1 first", 4'b0001, 1'b1);
        req = 4'b1000;
        q_ready = 1'b1;
        push(4'b0110, 2'd3);
        step("t1 second", 4'b1000, 1'b1);
        req = 4'b0000;
        step("t1 drain", 4'b0000, 1'b0);

        // Test 3: burst, back-to-back loads with q_ready held high
        set_data(0, 4'b1100);
        set_data(1, 4'b1101);
        set_data(2, 4'b1111);
        set_data(3, 4'b0110);
        req = 4'b1111;
        push(4'b1100, 2'd0);
        push(4'b1101, 2'd1);
        push(4'b1111, 2'd2);
        push(4'b0110, 2'd3);
        step("t3 g0", 4'b0001, 1'b1);
        req = 4'b1110;
        step("t3 g1", 4'b0010, 1'b1);
        req = 4'b1100;
        step("t3 g2", 4'b0100, 1'b1);
        req = 4'b1000;
        step("t3 g3", 4'b1000, 1'b1);
        req = 4'b0000;
        step("t3 end", 4'b0000, 1'b0);
        q_ready = 1'b0;

        // Test 5: fairness between req0 and req2, q_ready pulsed 1 cycle in 3
        set_data(0, 4'b1100);
        set_data(2, 4'b1111);
        req = 4'b0101;
        for (int g = 0; g < 4; g++) begin
`ifdef PIPO_ARB_FIXED_PRIO_EN
            push(4'b1100, 2'd0);
            step("t5 grant", 4'b0001, 1'b1);
`else
            if (g % 2 == 0) begin
                push(4'b1100, 2'd0);
                step("t5 grant", 4'b0001, 1'b1);
            end else begin
                push(4'b1111, 2'd2);
                step("t5 grant", 4'b0100, 1'b1);
            end
`endif
            q_ready = 1'b0;
            step("t5 wait", 4'b0000, 1'b1);
            step("t5 wait", 4'b0000, 1'b1);
            q_ready = 1'b1;
        end
        req = 4'b0000;
        step("t5 drain", 4'b0000, 1'b0);
        q_ready = 1'b0;

        // Test 2: single request held until q_ready
        set_data(0, 4'b1100);
        req = 4'b0001;
        push(4'b1100, 2'd0);
        step("t2 load", 4'b0001, 1'b1);
        req = 4'b0000;
        step("t2 hold", 4'b0000, 1'b1);
        step("t2 hold", 4'b0000, 1'b1);
        chk("t2 q held", 32'(q), 32'hC);
        q_ready = 1'b1;
        step("t2 drain", 4'b0000, 1'b0);
        chk("t2 q kept", 32'(q), 32'hC);
        chk("t2 q_src kept", 32'(q_src), 32'd0);
        q_ready = 1'b0;

        // Test 4: backpressure with req1 pending
        set_data(0, 4'b0011);
        req = 4'b0001;
        push(4'b0011, 2'd0);
        step("t4 load", 4'b0001, 1'b1);
        set_data(1, 4'b1010);
        req = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            step("t4 stall", 4'b0000, 1'b1);
            chk("t4 stall q", 32'(q), 32'h3);
            chk("t4 stall q_src", 32'(q_src), 32'd0);
        end
        q_ready = 1'b1;
        push(4'b1010, 2'd1);
        step("t4 reload", 4'b0010, 1'b1);
        req = 4'b0000;
        step("t4 drain", 4'b0000, 1'b0);

        // Test 6: req0 held high, one-cycle mask forces alternating grants
        set_data(0, 4'b0101);
        req = 4'b0001;
        for (int r = 0; r < 3; r++) begin
            push(4'b0101, 2'd0);
            step("t6 grant", 4'b0001, 1'b1);
            step("t6 masked", 4'b0000, 1'b0);
        end
        req = 4'b0000;
        step("t6 idle", 4'b0000, 1'b0);
        q_ready = 1'b0;

        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
